mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the 4:1 mux datapath between four requesters.
//  Drives the mux 'select' input and a one-hot grant back to the requesters.
//  Enforces a maximum hold time so that no single requester can starve the others.
//  Sits directly in front of the mux instance. Its 'select' output feeds mux.select.
// PARAMETERS
//  N_REQ     4   number of requesters; fixed at 4 to match the 4:1 mux
//  SEL_W     2   select width, log2(N_REQ)
//  MAX_HOLD  8   maximum consecutive grant cycles per ownership; legal range 2..255
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  en           in   1      arbitration enable
//  req          in   N_REQ  request vector, bit i = requester i
//  grant        out  N_REQ  one-hot grant, registered
//  select       out  SEL_W  binary index of the granted requester, to mux.select, registered
//  grant_valid  out  1      high while grant is non-zero, registered
// BEHAVIOUR
//  - Interface: one clock, clk; reset rst_n is asynchronous and active-low.
//  - Reset (async, any time, including mid-grant):
//    - grant=0, select=0, grant_valid=0.
//    - ptr=0, hold_cnt=0, state=IDLE.
//  - State machine: IDLE, GRANT.
//    - ptr is the round-robin start index.
//    - owner is the index of the currently granted requester.
//  - Pick function: the first i with req[i]=1, searching ptr, ptr+1, ... with wrap mod 4.
//  - IDLE:
//    - If en=1 and req!=0: next edge -> GRANT, grant=onehot(pick), select=pick,
//      grant_valid=1, hold_cnt=0.
//    - Latency from req to grant is 1 cycle.
//  - GRANT, release condition evaluated every edge:
//    rel = !en | !req[owner] | (hold_cnt==MAX_HOLD-1).
//    - rel=0: grant, select and owner are held; hold_cnt increments.
//    - rel=1: ptr <= owner+1 (mod 4). In the same edge, re-pick from owner+1 using the
//      current req (with owner's bit masked only if req[owner]=0).
//      - Candidate found and en=1: stay in GRANT with the new owner, hold_cnt=0.
//        There is no idle bubble between owners.
//      - No candidate, or en=0: -> IDLE, grant=0, grant_valid=0.
//  - Owner granted for MAX_HOLD cycles with no other requester pending: the re-pick wraps
//    back to the same owner. grant stays high continuously and hold_cnt restarts at 0.
//  - select holds its last value while grant_valid=0. It is never driven to X.
//  - Requests that rise and fall while another requester owns the grant are not queued.
//  - en=0 during IDLE: no grant is issued and ptr is unchanged.
//  - hold_cnt is 8 bits wide and saturates logically at MAX_HOLD-1; it never wraps.
//  - Invariants checked by the bench:
//    - $onehot0(grant).
//    - grant_valid == |grant.
//    - When grant_valid=1: grant == 1<<select.
// STRUCTURE
//  - Package mux_arb_pkg:
//    - N_REQ, SEL_W, MAX_HOLD_DEFAULT constants.
//    - state_t enum {IDLE, GRANT}.
//    - onehot-to-index helper function.
//  - Sub-module rr_pick: combinational search (req, start_ptr) -> found, idx.
//    Instanced once and used in both IDLE and release.
//  - Top level holds state, ptr, owner, hold_cnt and the output registers.
// TESTING
//  1. Reset mid-grant: granted 0100, drop rst_n between edges
//     -> grant=0000, select=00, grant_valid=0 immediately, without waiting for a clock edge.
//  2. Single request: req=0100 from IDLE
//     -> after 1 edge: grant=0100, select=10, grant_valid=1; held while req[2]=1.
//  3. Full contention: req=1111 from reset, MAX_HOLD=8
//     -> owners 0,1,2,3,0 in turn, 8 cycles each, back-to-back with no bubble.
//  4. Early release: owner 0, req changes 0001 -> 1010
//     -> next edge: grant=0010, select=01. Then owner 1 drops -> requester 3 is granted
//        (wrap order starts at 2).
//  5. Lone timeout: req=1000 held for 20 cycles
//     -> grant=1000 continuously for all 20 cycles; hold_cnt resets every 8 cycles.
//  6. Enable gating: en=0 while owner 2 is granted
//     -> next edge: grant=0000, grant_valid=0, select stays 10.
//     Then en=1 with req=0101 -> requester 0 is granted (ptr=3 wraps to 0).

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int N_REQ            = 4;
  localparam int SEL_W            = 2;
  localparam int MAX_HOLD_DEFAULT = 8;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational round-robin search: first set request at or after start_ptr, wrapping mod N_REQ.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start_ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  // The index adder is SEL_W bits wide, so the wrap past the last requester is free.
  always_comb begin
    onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      logic [SEL_W-1:0] cand;
      cand = start_ptr + SEL_W'(k);
      if (onehot == '0 && req[cand]) onehot[cand] = 1'b1;
    end
  end

  assign found = |onehot;
  assign idx   = onehot_to_idx(onehot);

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select, with a bounded hold time per owner.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] select,
  output logic             grant_valid
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [7:0]       hold_cnt;

  logic [SEL_W-1:0] after_owner;
  logic [SEL_W-1:0] start_ptr;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic             rel;

  // select doubles as the owner register; it is only meaningful while in GRANT.
  assign after_owner = select + SEL_W'(1);
  assign start_ptr   = (state == IDLE) ? ptr : after_owner;
  assign rel         = !en || !req[select] || (hold_cnt == 8'(MAX_HOLD - 1));

  rr_pick u_pick (
    .req       (req),
    .start_ptr (start_ptr),
    .found     (pick_found),
    .idx       (pick_idx),
    .onehot    (pick_onehot)
  );

  // On release the search starts after the owner, so a lone requester wraps back onto itself
  // and keeps its grant without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      select      <= '0;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en && pick_found) begin
            state       <= GRANT;
            grant       <= pick_onehot;
            select      <= pick_idx;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        GRANT: begin
          if (!rel) begin
            hold_cnt <= hold_cnt + 8'd1;
          end else begin
            ptr <= after_owner;
            if (en && pick_found) begin
              grant    <= pick_onehot;
              select   <= pick_idx;
              hold_cnt <= '0;
            end else begin
              state       <= IDLE;
              grant       <= '0;
              grant_valid <= 1'b0;
              hold_cnt    <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter with hand-computed expectations.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] select;
  logic       grant_valid;

  int checks = 0;
  int errors = 0;

  mux_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .req         (req),
    .grant       (grant),
    .select      (select),
    .grant_valid (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Outputs plus the structural invariants that must hold in every cycle.
  task automatic checkState(input string tag, input logic [3:0] expGrant, input logic [1:0] expSel,
                            input logic expValid);
    checkOutput({tag, ".grant"}, 8'(grant), 8'(expGrant));
    checkOutput({tag, ".select"}, 8'(select), 8'(expSel));
    checkOutput({tag, ".valid"}, 8'(grant_valid), 8'(expValid));
    checkOutput({tag, ".onehot0"}, 8'($onehot0(grant)), 8'd1);
    checkOutput({tag, ".validOr"}, 8'(grant_valid), 8'(|grant));
    if (grant_valid) checkOutput({tag, ".selMatch"}, 8'(grant), 8'(4'b0001 << select));
  endtask

  task automatic applyStimulus(input logic enVal, input logic [3:0] reqVal);
    en  = enVal;
    req = reqVal;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;
    #1;
    checkState("reset", 4'b0000, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] single request");
    applyStimulus(1'b1, 4'b0100);
    checkState("single", 4'b0100, 2'd2, 1'b1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 4'b0100);
      checkOutput("singleHold", 8'(grant), 8'h04);
    end

    $display("[TB] reset mid-grant");
    #2;
    rst_n = 1'b0;
    #1;
    checkState("asyncReset", 4'b0000, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] full contention");
    applyStimulus(1'b1, 4'b1111);
    for (int c = 0; c < 40; c++) begin
      logic [1:0] expOwner;
      expOwner = 2'((c / 8) % 4);
      checkOutput("contentionGrant", 8'(grant), 8'(4'b0001 << expOwner));
      checkOutput("contentionValid", 8'(grant_valid), 8'd1);
      applyStimulus(1'b1, 4'b1111);
    end

    $display("[TB] early release");
    pulseReset();
    applyStimulus(1'b1, 4'b0001);
    checkState("early0", 4'b0001, 2'd0, 1'b1);
    applyStimulus(1'b1, 4'b1010);
    checkState("early1", 4'b0010, 2'd1, 1'b1);
    applyStimulus(1'b1, 4'b1000);
    checkState("early3", 4'b1000, 2'd3, 1'b1);

    $display("[TB] lone timeout");
    pulseReset();
    applyStimulus(1'b1, 4'b1000);
    for (int c = 0; c < 20; c++) begin
      checkOutput("loneGrant", 8'(grant), 8'h08);
      checkOutput("loneHold", dut.hold_cnt, 8'(c % 8));
      if (c < 19) applyStimulus(1'b1, 4'b1000);
    end

    $display("[TB] enable gating");
    pulseReset();
    applyStimulus(1'b0, 4'b1111);
    checkState("idleDisabled", 4'b0000, 2'd0, 1'b0);
    applyStimulus(1'b1, 4'b0100);
    checkState("gate2", 4'b0100, 2'd2, 1'b1);
    applyStimulus(1'b0, 4'b0100);
    checkState("gateOff", 4'b0000, 2'd2, 1'b0);
    applyStimulus(1'b1, 4'b0101);
    checkState("gateWrap", 4'b0001, 2'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
